tdm_deframer: RTL and testbench
===============================

TDM_DEFRAMER -- requirements
Module: tdm_deframer

Interface
REQ-001 FRAMES_TO_LOCK, 2, consecutive correctly placed sync markers required to enter LOCKED; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 bit_en  input  1  serial bit strobe; din and sync_in are sampled only in cycles where bit_en=1.
REQ-005 din  input  1  serial TDM data; one slot bit per bit_en cycle, 4 slots per frame.
REQ-006 sync_in  input  1  frame marker; 1 marks the current bit as slot 0.
REQ-007 out_data  output  4  deframed frame; bit k = slot k value.
REQ-008 out_valid  output  1  out_data holds an undelivered frame.
REQ-009 out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1.
REQ-010 locked  output  1  1 while the state machine is in LOCKED.
REQ-011 sync_err  output  1  one-cycle pulse on sync misplacement after leaving HUNT.
REQ-012 overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-013 The block SHALL implement states HUNT, CONFIRM, LOCKED, a 2-bit slot counter, a 4-bit count of good syncs, and a 3-bit assembly register.
REQ-014 Slot counter SHALL advance by 1 modulo 4 only on bit_en cycles outside HUNT; it wraps 3 -> 0 with no extra cycle.
REQ-015 HUNT: on bit_en with sync_in=1, store din as slot 0, set slot counter to 1 and good count to 1, go to CONFIRM (or directly to LOCKED when FRAMES_TO_LOCK=1); bit_en with sync_in=0 is ignored.
REQ-016 CONFIRM/LOCKED: each bit_en cycle stores din into assembly bit [slot]; for slot 0 the sync check precedes storage.
REQ-017 Sync check: sync_in=1 at slot 0 is correct; sync_in=0 at slot 0, or sync_in=1 at slots 1-3, is a misplacement.
REQ-018 Misplacement in CONFIRM or LOCKED: go to HUNT, discard the partial frame, pulse sync_err the next cycle; the offending bit is not re-evaluated as a HUNT sync.
REQ-019 CONFIRM: correct sync increments good count; reaching FRAMES_TO_LOCK moves to LOCKED in that same edge, and the frame beginning at that slot 0 is the first delivered frame.
REQ-020 LOCKED: on bit_en at slot 3 with no misplacement, the completed frame {din, assembly[2:0]} is offered to the output buffer.
REQ-021 Frames completed in CONFIRM SHALL never be delivered.
REQ-022 Latency: out_valid and out_data update on the clock edge that samples the slot-3 bit (visible the following cycle).
REQ-023 Output buffer is one entry; out_valid clears on out_valid & out_ready unless a new frame loads in the same edge.
REQ-024 Frame completion with out_valid=1 and out_ready=1 in the same cycle: load new frame, out_valid stays 1, no overrun.
REQ-025 Frame completion with out_valid=1 and out_ready=0: new frame dropped, old out_data held, overrun pulses one cycle.
REQ-026 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Leaving LOCKED SHALL NOT clear an already buffered frame; it remains deliverable.
REQ-028 locked SHALL be a registered decode of state == LOCKED.

Reset
REQ-029 rst_n=0 SHALL immediately force: state HUNT, slot counter 0, good count 0, assembly 0, out_data 4'h0, out_valid 0, locked 0, sync_err 0, overrun 0.
REQ-030 Reset mid-frame or with a buffered frame SHALL discard everything; after release, operation resumes in HUNT on the first clk edge.

Verification
REQ-031 FRAMES_TO_LOCK=2, out_ready=1, continuous bit_en, frames 4'hA, 4'h5, 4'h3 with sync on each slot 0 -> locked rises after frame 2 slot 0; deliveries 4'h5 then 4'h3, each out_valid one cycle; 4'hA not delivered.
REQ-032 Locked, sync_in=1 at slot 2 -> sync_err pulse, locked falls, partial frame lost; next sync restarts HUNT/CONFIRM sequence.
REQ-033 Locked, out_ready=0, two frames 4'h6 then 4'h9 -> out_data holds 4'h6, overrun pulses once at second frame's slot 3; raising out_ready delivers 4'h6 only.
REQ-034 out_valid=1 holding 4'h1, out_ready=1 in the same cycle frame 4'hE completes -> out_data becomes 4'hE, out_valid stays 1, no overrun.
REQ-035 bit_en toggled 1/0 every cycle during lock and frame 4'hC -> identical results to continuous bit_en, deliveries spaced by stall cycles.
REQ-036 rst_n asserted between slot 1 and slot 2 with buffered frame 4'h7 -> all outputs 0 asynchronously; no delivery of 4'h7 after release.

Source files
------------

// File: rtl/tdm_deframer.sv
// tdm_deframer: recovers 4-slot TDM frames from a serial stream with sync-marker lock tracking
module tdm_deframer #(
    parameter int FRAMES_TO_LOCK = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_en,
    input  logic       din,
    input  logic       sync_in,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_valid,
    output logic       locked,
    output logic       sync_err,
    output logic       overrun
);
    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] CONFIRM = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam logic [3:0] FTL     = 4'(FRAMES_TO_LOCK);

    logic [1:0] state_q, state_d;
    logic [1:0] slot_q, slot_d;
    logic [3:0] good_q, good_d;
    logic [2:0] asm_q, asm_d;
    logic [3:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       locked_q, locked_d;
    logic       sync_err_q, sync_err_d;
    logic       overrun_q, overrun_d;
    logic       misplaced, frame_done, load;
    logic [3:0] good_inc;

    // frame tracking: hunt for a marker, confirm alignment, then assemble slots while locked
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        good_d     = good_q;
        asm_d      = asm_q;
        sync_err_d = 1'b0;
        frame_done = 1'b0;
        misplaced  = (slot_q == 2'd0) ? !sync_in : sync_in;
        good_inc   = good_q + 4'd1;
        if (bit_en) begin
            if (state_q == HUNT) begin
                if (sync_in) begin
                    asm_d   = {2'b00, din};
                    slot_d  = 2'd1;
                    good_d  = 4'd1;
                    state_d = (FTL == 4'd1) ? LOCKED : CONFIRM;
                end
            end else if (misplaced) begin
                state_d    = HUNT;
                slot_d     = 2'd0;
                good_d     = 4'd0;
                asm_d      = 3'd0;
                sync_err_d = 1'b1;
            end else begin
                slot_d   = slot_q + 2'd1;
                asm_d[0] = (slot_q == 2'd0) ? din : asm_q[0];
                asm_d[1] = (slot_q == 2'd1) ? din : asm_q[1];
                asm_d[2] = (slot_q == 2'd2) ? din : asm_q[2];
                if (state_q == CONFIRM && slot_q == 2'd0) begin
                    good_d  = good_inc;
                    state_d = (good_inc >= FTL) ? LOCKED : CONFIRM;
                end
                frame_done = (state_q == LOCKED) && (slot_q == 2'd3);
            end
        end
    end

    // single-entry output buffer: a completed frame loads only if the slot is free or draining now
    always_comb begin
        load        = frame_done && (!out_valid_q || out_ready);
        out_data_d  = load ? {din, asm_q} : out_data_q;
        out_valid_d = load || (out_valid_q && !out_ready);
        overrun_d   = frame_done && out_valid_q && !out_ready;
        locked_d    = (state_d == LOCKED);
    end

    // state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot_q      <= 2'd0;
            good_q      <= 4'd0;
            asm_q       <= 3'd0;
            out_data_q  <= 4'h0;
            out_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            good_q      <= good_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            locked_q    <= locked_d;
            sync_err_q  <= sync_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign locked    = locked_q;
    assign sync_err  = sync_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_tdm_deframer.sv
// tb_tdm_deframer: directed checks of lock acquisition, delivery, overrun and reset behaviour
module tb_tdm_deframer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       din = 1'b0;
    logic       sync_in = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       out_valid, locked, sync_err, overrun;
    int         n_checks = 0;
    int         n_fails = 0;
    logic [3:0] got_q[$];

    tdm_deframer #(.FRAMES_TO_LOCK(2)) dut (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .din(din), .sync_in(sync_in),
        .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
        .locked(locked), .sync_err(sync_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // inputs only change just after a rising edge, so a handshake seen here happens on the next edge
    always @(negedge clk)
        if (rst_n && out_valid && out_ready) got_q.push_back(out_data);

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic en, input logic d, input logic s);
        bit_en = en;
        din = d;
        sync_in = s;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        din = 1'b0;
        sync_in = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] f);
        for (int k = 0; k < 4; k++) tick(1'b1, f[k], k == 0);
    endtask

    initial begin
        #12;
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_err", sync_err, 0);
        check("rst_ovr", overrun, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        // acquisition: A confirms, 5 locks and is delivered, then 3
        tick(1'b1, 1'b0, 1'b1);
        check("hunt_to_confirm_locked", locked, 0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("confirm_frame_undelivered", out_valid, 0);
        tick(1'b1, 1'b1, 1'b1);
        check("lock_on_frame2", locked, 1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("valid_before_slot3", out_valid, 0);
        tick(1'b1, 1'b0, 1'b0);
        check("frame5_valid", out_valid, 1);
        check("frame5_data", out_data, 5);
        tick(1'b1, 1'b1, 1'b1);
        check("frame5_one_cycle", out_valid, 0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("frame3_data", out_data, 3);
        // misplaced sync at slot 2 while locked
        tick(1'b1, 1'b0, 1'b1);
        check("deliv_count_a", got_q.size(), 2);
        check("deliv_0", got_q[0], 5);
        check("deliv_1", got_q[1], 3);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        check("misplace_err", sync_err, 1);
        check("misplace_unlock", locked, 0);
        tick(1'b0, 1'b0, 1'b0);
        check("err_pulse_end", sync_err, 0);
        // relock from scratch; the offending bit must not have counted as a sync
        out_ready = 1'b0;
        tick(1'b1, 1'b1, 1'b1);
        check("relock_not_early", locked, 0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check("relock_confirm_undeliv", out_valid, 0);
        tick(1'b1, 1'b0, 1'b1);
        check("relock", locked, 1);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("f6_valid", out_valid, 1);
        check("f6_data", out_data, 6);
        check("f6_no_ovr", overrun, 0);
        send_frame(4'h9);
        check("f9_overrun", overrun, 1);
        check("f9_hold_data", out_data, 6);
        tick(1'b0, 1'b0, 1'b0);
        check("ovr_pulse_end", overrun, 0);
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, 6);
        out_ready = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        check("drain_valid", out_valid, 0);
        check("deliv_count_b", got_q.size(), 3);
        check("deliv_2", got_q[2], 6);
        // simultaneous drain and load
        out_ready = 1'b0;
        send_frame(4'h1);
        check("f1_data", out_data, 1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick(1'b1, 1'b1, 1'b0);
        check("swap_valid", out_valid, 1);
        check("swap_data", out_data, 14);
        check("swap_no_ovr", overrun, 0);
        tick(1'b0, 1'b0, 1'b0);
        check("swap_drain", out_valid, 0);
        check("deliv_count_c", got_q.size(), 5);
        check("deliv_3", got_q[3], 1);
        check("deliv_4", got_q[4], 14);
        // stalled bit strobe
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, k >= 2, k == 0);
            if (k < 3) check("stall_no_valid", out_valid, 0);
            tick(1'b0, 1'b1, 1'b1);
        end
        check("stall_locked", locked, 1);
        check("deliv_count_d", got_q.size(), 6);
        check("deliv_5", got_q[5], 12);
        // reset with buffered frame and a partial frame in flight
        out_ready = 1'b0;
        send_frame(4'h7);
        check("f7_data", out_data, 7);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_locked", locked, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_no_deliv", got_q.size(), 6);
        send_frame(4'h2);
        check("post_rst_hunt", locked, 0);
        tick(1'b1, 1'b0, 1'b1);
        check("post_rst_relock", locked, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
